// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and fetch state encoding for the MIPS pipeline
package mips_pkg;

    typedef logic [0:0] fetchState_t;

    localparam fetchState_t RUN     = 1'b0;
    localparam fetchState_t JR_WAIT = 1'b1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fd_pipe_reg.sv
// rtl/fd_pipe_reg.sv - F->D pipeline register with hold, flush and valid tracking
module fd_pipe_reg
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            flush,
    input  logic [31:0]     inInstr,
    input  logic [XLEN-1:0] inPcPlus4,
    input  logic            inValid,
    output logic [31:0]     outInstr,
    output logic [XLEN-1:0] outPcPlus4,
    output logic            outValid
);

    // Flush beats hold; an invalid load always writes a NOP so decode never sees stale bits
    always_ff @(posedge clk) begin
        if (rst) begin
            outInstr   <= NOP_INSTR;
            outPcPlus4 <= '0;
            outValid   <= 1'b0;
        end else if (flush) begin
            outInstr <= NOP_INSTR;
            outValid <= 1'b0;
        end else if (!hold) begin
            outInstr   <= inValid ? inInstr : NOP_INSTR;
            outPcPlus4 <= inPcPlus4;
            outValid   <= inValid;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC register, next-PC selection, jr wait FSM and F->D register
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             branch_taken_d,
    input  logic [XLEN-1:0]  branch_target_d,
    input  logic             jump_d,
    input  logic             jr_d,
    input  logic             jr_ready_d,
    input  logic [XLEN-1:0]  jr_target_d,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_d,
    output logic [XLEN-1:0]  pcplus4_d,
    output logic             valid_d,
    output logic             redirect,
    output logic [CNT_W-1:0] bubble_cnt
);

    fetchState_t     state;
    fetchState_t     stateNext;
    logic [XLEN-1:0] pcF;
    logic [XLEN-1:0] pcPlus4F;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] jumpTarget;
    logic [XLEN-1:0] redirectTarget;
    logic            pcHold;
    logic            fdHold;
    logic            bubbleLoad;

    assign imem_addr  = pcF;
    assign pcPlus4F   = pcF + XLEN'(PC_INC);
    assign jumpTarget = {pcplus4_d[XLEN-1:28], instr_d[25:0], 2'b00};

    // Next-PC priority: pending/ready jr first, then branch, jump, fetch stall, sequential
    always_comb begin
        stateNext      = state;
        redirect       = 1'b0;
        redirectTarget = jr_target_d;
        pcHold         = 1'b0;
        fdHold         = stall_d;
        if (state == JR_WAIT) begin
            if (jr_ready_d) begin
                redirect  = 1'b1;
                stateNext = RUN;
            end else begin
                pcHold = 1'b1;
                fdHold = 1'b1;
            end
        end else if (valid_d && jr_d) begin
            if (jr_ready_d) begin
                redirect = 1'b1;
            end else begin
                stateNext = JR_WAIT;
                pcHold    = 1'b1;
                fdHold    = 1'b1;
            end
        end else if (valid_d && branch_taken_d) begin
            redirect       = 1'b1;
            redirectTarget = branch_target_d;
        end else if (valid_d && jump_d) begin
            redirect       = 1'b1;
            redirectTarget = jumpTarget;
        end else if (stall_f) begin
            pcHold = 1'b1;
        end
    end

    assign pcNext     = redirect ? redirectTarget : (pcHold ? pcF : pcPlus4F);
    // A bubble enters decode on a squash, or when fetch stalls while decode drains
    assign bubbleLoad = redirect || (!fdHold && stall_f);

    // PC register and jr wait state
    always_ff @(posedge clk) begin
        if (rst) begin
            pcF   <= RESET_PC;
            state <= RUN;
        end else begin
            pcF   <= pcNext;
            state <= stateNext;
        end
    end

    // Saturating count of bubbles written into the F->D register
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubbleLoad && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    fd_pipe_reg #(
        .XLEN (XLEN)
    ) u_fdReg (
        .clk        (clk),
        .rst        (rst),
        .hold       (fdHold),
        .flush      (redirect),
        .inInstr    (imem_rdata),
        .inPcPlus4  (pcPlus4F),
        .inValid    (!stall_f),
        .outInstr   (instr_d),
        .outPcPlus4 (pcplus4_d),
        .outValid   (valid_d)
    );

endmodule
